display_history: RTL and testbench
==================================

// Module: display_history
// PURPOSE
//   Captures 12-bit words written by the CPU output port into a DEPTH-entry history ring.
//   Produces the 12-bit value for the hex seven-segment driver (disp_data feeds its data input).
//   Live mode shows the newest word; two debounced buttons step back and forward through history.
//   Sits between the CPU output port and the seven-segment display driver.
// PARAMETERS
//   DEPTH       8   history entries; power of 2, 2..16
//   DATA_W      12  output word width
//   DEBOUNCE_W  16  debounce counter width; button must be stable 2**DEBOUNCE_W-1 cycles
// PORTS
//   clk        in   1       system clock; one clock domain
//   rst_n      in   1       reset, asynchronous, active-low
//   out_valid  in   1       CPU output-port write strobe, one cycle per word
//   out_data   in   DATA_W  word written; sampled when out_valid=1
//   btn_prev   in   1       raw pushbutton (async, bouncy): step to older entry
//   btn_next   in   1       raw pushbutton (async, bouncy): step to newer entry / return to live
//   disp_data  out  DATA_W  value to display (registered)
//   live       out  1       1 = following newest entry
//   offset     out  4       entries back from newest (0 = newest)
//   count      out  5       valid entries, saturates at DEPTH
//   overflow   out  1       sticky: an entry was overwritten since reset
// BEHAVIOUR
// - Reset (async assert, sync release): wp=0, count=0, offset=0, live=1, overflow=0, disp_data=0.
//   Debouncer state is cleared. Ring contents are don't-care.
// - Write (out_valid=1): mem[wp]<=out_data; wp<=wp+1 mod DEPTH.
//   count<=min(count+1,DEPTH).
//   If count==DEPTH before the write, overflow<=1 (oldest overwritten).
// - Buttons: 2-FF synchroniser, then debounce counter.
//   The counter resets on any change of the synchronised level.
//   When the counter hits all-ones, the debounced level takes the synchronised value.
//   A debounced 0->1 gives a one-cycle press pulse.
// - prev press (offset < count-1): live<=0, offset<=offset+1. Otherwise no change.
//   A prev press with count<=1 is ignored; the block stays live.
// - next press: if offset>0, offset<=offset-1; if offset==0, live<=1.
// - Both presses in the same cycle: both ignored.
// - Write while live: offset stays 0, so the display tracks the newest word.
// - Write while browsing: offset<=min(offset+1, DEPTH-1) so the viewed entry stays pinned.
//   If that entry is overwritten, the view clamps to the oldest entry.
// - Write and press in the same cycle: the press is applied first, then the write adjustment.
//   Both use registered values; one next-state computation.
// - disp_data is registered each cycle:
//   disp_data = (count==0) ? 0 : mem[(wp-1-offset) mod DEPTH], using next-state values.
//   The new word is visible on disp_data 1 cycle after the out_valid cycle.
// - Pointer arithmetic is modulo DEPTH (log2 DEPTH bits). count is one bit wider.
// STRUCTURE
// - Shared include file: DATA_W default and the history DEPTH constant.
//   These are shared with the CPU top and the seven-segment instance wiring.
// - Sub-module button_debounce (synchroniser + counter + edge pulse), parameter DEBOUNCE_W.
//   Instantiated twice (prev, next).
// - Top holds the ring (distributed RAM or register array, async read), pointers and view FSM.
//   View FSM states: LIVE, BROWSE.
// TESTING (bench uses DEBOUNCE_W=4)
// - Reset, no writes -> disp_data=0, count=0, live=1.
//   prev press -> no change.
// - Write 0x123, 0x456, 0xABC -> disp_data=0xABC one cycle after last strobe; count=3; overflow=0.
// - Then 2x prev -> offset=2, disp_data=0x123, live=0.
//   3rd prev ignored. 3x next -> 0x456, 0xABC, then live=1.
// - Write 9 words 0x001..0x009 (DEPTH=8) -> count=8, overflow=1.
//   7x prev -> disp_data=0x002.
//   Write 0x00A -> offset stays 7, disp_data=0x003 (clamped to oldest).
// - Browse at offset 1 over 0x0AA,0xBBB; write 0xCCC in the same cycle as a next press
//   -> offset=1, disp_data=0xBBB.
// - Glitch btn_prev high for 3 cycles -> no press.
//   Both buttons pressed together -> no change.
//   Assert rst_n mid-browse -> immediate reset values.

Source files
------------

// File: rtl/display_history_pkg.sv
// display_history_pkg: history depth, word width and view-state type shared by the
// CPU top, the seven-segment wiring and the display history block.
package display_history_pkg;
   localparam int HIST_DEPTH  = 8;
   localparam int HIST_DATA_W = 12;
   typedef enum logic {VIEW_LIVE, VIEW_BROWSE} view_state_e;
endpackage

// File: rtl/display_history_button_debounce.sv
// button_debounce: 2-FF synchroniser, stability counter and rising-edge press pulse
// for one raw pushbutton.
module button_debounce #(
   parameter int DEBOUNCE_W = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic press_o
);
   localparam logic [DEBOUNCE_W-1:0] ONES = '1;
   logic [1:0]            sync_q, sync_d;
   logic                  last_q, last_d;
   logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
   logic                  level_q, level_d;
   logic                  press_q, press_d;
   always_comb begin
      sync_d  = {sync_q[0], btn_i};
      last_d  = sync_q[1];
      // any change of the synchronised level restarts the stability count
      cnt_d   = (sync_q[1] != last_q) ? '0 : (cnt_q == ONES) ? cnt_q : cnt_q + 1'b1;
      level_d = (cnt_q == ONES) ? last_q : level_q;
      press_d = level_d & ~level_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end
   assign press_o = press_q;
endmodule

// File: rtl/display_history.sv
// display_history: ring of recent CPU output words with a live/browse view for the
// seven-segment driver, stepped by two debounced buttons.
module display_history
   import display_history_pkg::*;
#(
   parameter int DEPTH      = HIST_DEPTH,
   parameter int DATA_W     = HIST_DATA_W,
   parameter int DEBOUNCE_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              out_valid,
   input  logic [DATA_W-1:0] out_data,
   input  logic              btn_prev,
   input  logic              btn_next,
   output logic [DATA_W-1:0] disp_data,
   output logic              live,
   output logic [3:0]        offset,
   output logic [4:0]        count,
   output logic              overflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [3:0]    OFF_MAX = 4'(DEPTH - 1);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wp_q, wp_d, rd_idx;
   logic [CW-1:0]     count_q, count_d;
   logic [3:0]        offset_q, offset_d;
   view_state_e       state_q, state_d;
   logic              overflow_q, overflow_d;
   logic [DATA_W-1:0] disp_q, disp_d;
   logic              press_prev, press_next, go_prev, go_next;
   button_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_prev (
      .clk(clk), .rst_n(rst_n), .btn_i(btn_prev), .press_o(press_prev)
   );
   button_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_next (
      .clk(clk), .rst_n(rst_n), .btn_i(btn_next), .press_o(press_next)
   );
   always_comb begin
      go_prev  = press_prev & ~press_next;
      go_next  = press_next & ~press_prev;
      state_d  = state_q;
      offset_d = offset_q;
      if (go_prev && (5'(offset_q) + 5'd1 < 5'(count_q))) begin
         state_d  = VIEW_BROWSE;
         offset_d = offset_q + 4'd1;
      end
      if (go_next) begin
         if (offset_q != 4'd0) offset_d = offset_q - 4'd1;
         else                  state_d  = VIEW_LIVE;
      end
      // a write while browsing keeps the viewed entry pinned, clamping at the oldest
      if (out_valid && state_d == VIEW_BROWSE)
         offset_d = (offset_d == OFF_MAX) ? OFF_MAX : offset_d + 4'd1;
      wp_d       = out_valid ? wp_q + PW'(1) : wp_q;
      count_d    = (out_valid && count_q != FULL) ? count_q + CW'(1) : count_q;
      overflow_d = overflow_q | (out_valid && count_q == FULL);
      rd_idx     = wp_d - PW'(1) - offset_d[PW-1:0];
      // the word being written this cycle is not yet in the ring, so bypass it
      disp_d     = (count_d == '0) ? '0 :
                   (out_valid && rd_idx == wp_q) ? out_data : mem_q[rd_idx];
   end
   always_ff @(posedge clk) begin
      if (out_valid) mem_q[wp_q] <= out_data;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q       <= '0;
         count_q    <= '0;
         offset_q   <= '0;
         state_q    <= VIEW_LIVE;
         overflow_q <= 1'b0;
         disp_q     <= '0;
      end else begin
         wp_q       <= wp_d;
         count_q    <= count_d;
         offset_q   <= offset_d;
         state_q    <= state_d;
         overflow_q <= overflow_d;
         disp_q     <= disp_d;
      end
   end
   assign disp_data = disp_q;
   assign live      = (state_q == VIEW_LIVE);
   assign offset    = offset_q;
   assign count     = 5'(count_q);
   assign overflow  = overflow_q;
endmodule

// File: tb/tb_display_history.sv
// tb_display_history: directed vector table, hand-written corner sequences and
// randomized operations checked against a queue-based history model.
module tb_display_history;
   localparam int DEPTH = 8;
   typedef enum int {OP_W, OP_P, OP_N, OP_B, OP_G} op_e;
   typedef struct {
      op_e         op;
      logic [11:0] data;
      logic [11:0] disp;
      int          cnt;
      int          off;
      bit          live;
      bit          ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        out_valid = 1'b0;
   logic [11:0] out_data = '0;
   logic        btn_prev = 1'b0;
   logic        btn_next = 1'b0;
   logic [11:0] disp_data;
   logic        live;
   logic [3:0]  offset;
   logic [4:0]  count;
   logic        overflow;

   int total = 0;
   int bad = 0;
   vec_t vecs[$];

   logic [11:0] hist[$];
   int          m_off;
   bit          m_live, m_ovf;

   display_history #(.DEPTH(DEPTH), .DATA_W(12), .DEBOUNCE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .out_valid(out_valid), .out_data(out_data),
      .btn_prev(btn_prev), .btn_next(btn_next), .disp_data(disp_data),
      .live(live), .offset(offset), .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [11:0] d, input int c, input int o,
                          input bit l, input bit v);
      chk({tag, " disp"}, 32'(disp_data), 32'(d));
      chk({tag, " count"}, 32'(count), c);
      chk({tag, " offset"}, 32'(offset), o);
      chk({tag, " live"}, 32'(live), 32'(l));
      chk({tag, " overflow"}, 32'(overflow), 32'(v));
   endtask

   task automatic m_reset();
      hist.delete();
      m_off = 0; m_live = 1; m_ovf = 0;
   endtask

   task automatic m_prev();
      if (m_off < hist.size() - 1) begin m_live = 0; m_off++; end
   endtask

   task automatic m_next();
      if (m_off > 0) m_off--; else m_live = 1;
   endtask

   task automatic m_write(input logic [11:0] d);
      hist.push_back(d);
      if (hist.size() > DEPTH) begin void'(hist.pop_front()); m_ovf = 1; end
      if (!m_live) m_off = (m_off + 1 > DEPTH - 1) ? DEPTH - 1 : m_off + 1;
   endtask

   task automatic m_check(input string tag);
      logic [11:0] exp_d;
      exp_d = (hist.size() == 0) ? 12'h000 : hist[hist.size() - 1 - m_off];
      chk_all(tag, exp_d, hist.size(), m_off, m_live, m_ovf);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; out_valid = 1'b0; btn_prev = 1'b0; btn_next = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      m_reset();
   endtask

   task automatic d_write(input logic [11:0] d);
      out_valid = 1'b1; out_data = d;
      @(negedge clk);
      out_valid = 1'b0;
      @(negedge clk);
      m_write(d);
   endtask

   task automatic d_press(input bit p, input bit n);
      btn_prev = p; btn_next = n;
      repeat (25) @(negedge clk);
      btn_prev = 1'b0; btn_next = 1'b0;
      repeat (25) @(negedge clk);
      if (p && !n) m_prev();
      if (n && !p) m_next();
   endtask

   task automatic apply(input op_e op, input logic [11:0] d);
      case (op)
         OP_W: d_write(d);
         OP_P: d_press(1, 0);
         OP_N: d_press(0, 1);
         OP_B: d_press(1, 1);
         default: begin
            btn_prev = 1'b1;
            repeat (3) @(negedge clk);
            btn_prev = 1'b0;
            repeat (25) @(negedge clk);
         end
      endcase
   endtask

   function automatic vec_t v(op_e op, logic [11:0] data, logic [11:0] disp, int cnt, int off,
                              bit l, bit ovf);
      vec_t r;
      r.op = op; r.data = data; r.disp = disp; r.cnt = cnt; r.off = off; r.live = l; r.ovf = ovf;
      return r;
   endfunction

   initial begin
      bit seen;
      vecs.push_back(v(OP_P, 0, 12'h000, 0, 0, 1, 0));
      vecs.push_back(v(OP_W, 12'h123, 12'h123, 1, 0, 1, 0));
      vecs.push_back(v(OP_W, 12'h456, 12'h456, 2, 0, 1, 0));
      vecs.push_back(v(OP_W, 12'hABC, 12'hABC, 3, 0, 1, 0));
      vecs.push_back(v(OP_P, 0, 12'h456, 3, 1, 0, 0));
      vecs.push_back(v(OP_P, 0, 12'h123, 3, 2, 0, 0));
      vecs.push_back(v(OP_P, 0, 12'h123, 3, 2, 0, 0));
      vecs.push_back(v(OP_N, 0, 12'h456, 3, 1, 0, 0));
      vecs.push_back(v(OP_N, 0, 12'hABC, 3, 0, 0, 0));
      vecs.push_back(v(OP_N, 0, 12'hABC, 3, 0, 1, 0));
      for (int i = 1; i <= 9; i++)
         vecs.push_back(v(OP_W, 12'(i), 12'(i), (i + 3 > 8) ? 8 : i + 3, 0, 1, i >= 6));
      for (int i = 1; i <= 7; i++)
         vecs.push_back(v(OP_P, 0, 12'(9 - i), 8, i, 0, 1));
      vecs.push_back(v(OP_W, 12'h00A, 12'h003, 8, 7, 0, 1));
      vecs.push_back(v(OP_G, 0, 12'h003, 8, 7, 0, 1));
      vecs.push_back(v(OP_B, 0, 12'h003, 8, 7, 0, 1));
      vecs.push_back(v(OP_N, 0, 12'h004, 8, 6, 0, 1));

      do_reset();
      chk_all("reset", 12'h000, 0, 0, 1, 0);
      foreach (vecs[i]) begin
         apply(vecs[i].op, vecs[i].data);
         chk_all($sformatf("vec%0d", i), vecs[i].disp, vecs[i].cnt, vecs[i].off,
                 vecs[i].live, vecs[i].ovf);
      end

      // next press and write landing on the same clock edge
      do_reset();
      d_write(12'h0AA);
      d_write(12'hBBB);
      d_press(1, 0);
      chk_all("pre_same", 12'h0AA, 2, 1, 0, 0);
      btn_next = 1'b1;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (dut.u_next.press_o) begin
            seen = 1;
            out_valid = 1'b1; out_data = 12'hCCC;
            @(negedge clk);
            out_valid = 1'b0;
         end
      end
      chk("next_press_seen", 32'(seen), 32'd1);
      btn_next = 1'b0;
      repeat (25) @(negedge clk);
      m_next(); m_write(12'hCCC);
      chk_all("same_cycle", 12'hBBB, 3, 1, 0, 0);

      // asynchronous reset mid-browse
      #2 rst_n = 1'b0;
      #1 chk_all("async_rst", 12'h000, 0, 0, 1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      m_reset();

      for (int i = 0; i < 150; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 5)      apply(OP_W, 12'($urandom));
         else if (r < 7) apply(OP_P, 0);
         else if (r < 9) apply(OP_N, 0);
         else            apply(OP_B, 0);
         m_check($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
